// File: rtl/mux_scan_sequencer.sv
// Scans a 4-to-1 mux through channels 0..3, dwelling SETTLE clocks on each,
// and presents the four samples as a frame over a valid/ready handshake.
module mux_scan_sequencer #(
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       mux_out,
    output logic       s1,
    output logic       s0,
    output logic [3:0] frame,
    output logic       valid,
    input  logic       ready,
    output logic       busy
);

    if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
        $error("mux_scan_sequencer: SETTLE must be in 1..15");
    end

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        HOLD
    } state_e;

    localparam logic [3:0] LAST = 4'(SETTLE - 1);

    state_e     state_q, state_d;
    logic [1:0] k_q, k_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] buf_q, buf_d;
    logic [3:0] frame_q, frame_d;
    logic       dwell_done;

    assign dwell_done = (cnt_q == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            k_q     <= 2'b00;
            cnt_q   <= 4'd0;
            buf_q   <= 3'b000;
            frame_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            frame_q <= frame_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        frame_d = frame_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SCAN;
                    k_d     = 2'b00;
                    cnt_d   = 4'd0;
                    buf_d   = 3'b000;
                end
            end
            SCAN: begin
                if (!dwell_done) begin
                    cnt_d = cnt_q + 4'd1;
                end else if (k_q == 2'd3) begin
                    // Select parks at 00 so HOLD/IDLE present channel 0.
                    frame_d = {mux_out, buf_q};
                    state_d = HOLD;
                    k_d     = 2'b00;
                    cnt_d   = 4'd0;
                end else begin
                    buf_d[k_q] = mux_out;
                    k_d        = k_q + 2'd1;
                    cnt_d      = 4'd0;
                end
            end
            HOLD: begin
                if (ready) begin
                    state_d = start ? SCAN : IDLE;
                    k_d     = 2'b00;
                    cnt_d   = 4'd0;
                    buf_d   = 3'b000;
                end
            end
            default: begin
                state_d = IDLE;
                k_d     = 2'b00;
                cnt_d   = 4'd0;
            end
        endcase
    end

    assign {s1, s0} = k_q;
    assign frame    = frame_q;
    assign valid    = (state_q == HOLD);
    assign busy     = (state_q != IDLE);

endmodule
